// File: rtl/pc_tx_frame_arbiter.sv
// rtl/pc_tx_frame_arbiter.sv - round-robin two-requester frame arbiter for a shared UART TX path
module pc_tx_frame_arbiter #(
  parameter int LEN_WIDTH  = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_arst_n,
  input  logic                  i_req_0,
  input  logic                  i_req_1,
  input  logic [LEN_WIDTH-1:0]  i_len_0,
  input  logic [LEN_WIDTH-1:0]  i_len_1,
  input  logic [DATA_WIDTH-1:0] i_data_0,
  input  logic [DATA_WIDTH-1:0] i_data_1,
  output logic                  o_gnt_0,
  output logic                  o_gnt_1,
  output logic                  o_ack_0,
  output logic                  o_ack_1,
  input  logic                  i_tx_rdy,
  output logic                  o_tx_wr,
  output logic [DATA_WIDTH-1:0] o_tx_data,
  output logic                  o_abort,
  output logic                  o_busy
);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t                 state_q, state_d;
  logic                   gnt_0_q, gnt_0_d;
  logic                   gnt_1_q, gnt_1_d;
  logic                   last_q, last_d;     // 1: requester 1 was granted last
  logic [LEN_WIDTH-1:0]   len_q, len_d;
  logic [LEN_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   abort_q, abort_d;
  logic                   busy_q;
  logic                   sel;                // 1: grant requester 1
  logic                   req_g;              // granted requester still requesting
  logic                   tx_wr;
  logic [LEN_WIDTH-1:0]   len_sel;

  // Datapath towards the UART: write strobe, byte mux and per-requester acks
  always_comb begin
    req_g     = (gnt_0_q & i_req_0) | (gnt_1_q & i_req_1);
    tx_wr     = (state_q == SEND) & i_tx_rdy & req_g;
    o_tx_wr   = tx_wr;
    o_ack_0   = tx_wr & gnt_0_q;
    o_ack_1   = tx_wr & gnt_1_q;
    o_tx_data = '0;
    if (state_q == SEND) begin
      o_tx_data = gnt_1_q ? i_data_1 : i_data_0;
    end
  end

  // Next-state logic: arbitration in IDLE, byte counting and abort in SEND
  always_comb begin
    state_d = state_q;
    gnt_0_d = gnt_0_q;
    gnt_1_d = gnt_1_q;
    last_d  = last_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    abort_d = 1'b0;
    sel     = (i_req_0 & i_req_1) ? ~last_q : i_req_1;
    len_sel = sel ? i_len_1 : i_len_0;
    case (state_q)
      IDLE: begin
        if (i_req_0 | i_req_1) begin
          state_d = SEND;
          gnt_0_d = ~sel;
          gnt_1_d = sel;
          last_d  = sel;
          len_d   = (len_sel == '0) ? LEN_WIDTH'(1) : len_sel;
          cnt_d   = '0;
        end
      end
      SEND: begin
        if (!req_g) begin
          state_d = DONE;
          abort_d = 1'b1;
          gnt_0_d = 1'b0;
          gnt_1_d = 1'b0;
        end else if (tx_wr) begin
          if (cnt_q == len_q - LEN_WIDTH'(1)) begin
            state_d = DONE;
            gnt_0_d = 1'b0;
            gnt_1_d = 1'b0;
          end else begin
            cnt_d = cnt_q + LEN_WIDTH'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        gnt_0_d = 1'b0;
        gnt_1_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset parks the pointer so requester 0 wins first
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_q <= IDLE;
      gnt_0_q <= 1'b0;
      gnt_1_q <= 1'b0;
      last_q  <= 1'b1;
      len_q   <= '0;
      cnt_q   <= '0;
      abort_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_0_q <= gnt_0_d;
      gnt_1_q <= gnt_1_d;
      last_q  <= last_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  assign o_gnt_0 = gnt_0_q;
  assign o_gnt_1 = gnt_1_q;
  assign o_abort = abort_q;
  assign o_busy  = busy_q;

endmodule

// File: tb/tb_pc_tx_frame_arbiter.sv
// tb/tb_pc_tx_frame_arbiter.sv - directed self-checking bench for pc_tx_frame_arbiter
module tb_pc_tx_frame_arbiter;

  logic       i_clk = 1'b0;
  logic       i_arst_n;
  logic       i_req_0, i_req_1;
  logic [3:0] i_len_0, i_len_1;
  logic [7:0] i_data_0, i_data_1;
  logic       o_gnt_0, o_gnt_1, o_ack_0, o_ack_1;
  logic       i_tx_rdy;
  logic       o_tx_wr;
  logic [7:0] o_tx_data;
  logic       o_abort, o_busy;

  int n_pass  = 0;
  int n_total = 0;

  pc_tx_frame_arbiter dut (
    .i_clk     (i_clk),
    .i_arst_n  (i_arst_n),
    .i_req_0   (i_req_0),
    .i_req_1   (i_req_1),
    .i_len_0   (i_len_0),
    .i_len_1   (i_len_1),
    .i_data_0  (i_data_0),
    .i_data_1  (i_data_1),
    .o_gnt_0   (o_gnt_0),
    .o_gnt_1   (o_gnt_1),
    .o_ack_0   (o_ack_0),
    .o_ack_1   (o_ack_1),
    .i_tx_rdy  (i_tx_rdy),
    .o_tx_wr   (o_tx_wr),
    .o_tx_data (o_tx_data),
    .o_abort   (o_abort),
    .o_busy    (o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0] ctab [11];
    logic       pat  [7];
    logic [7:0] exp_data;
    int         nw;

    ctab = '{3'b101, 3'b101, 3'b000, 3'b000, 3'b011, 3'b011,
             3'b000, 3'b000, 3'b101, 3'b101, 3'b000};
    pat  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    i_arst_n = 1'b0;
    i_req_0 = 1'b0; i_req_1 = 1'b0;
    i_len_0 = '0;   i_len_1 = '0;
    i_data_0 = '0;  i_data_1 = '0;
    i_tx_rdy = 1'b0;

    // reset state
    @(negedge i_clk); #1;
    chk("rst_gnt0", o_gnt_0, 0);
    chk("rst_gnt1", o_gnt_1, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_wr", o_tx_wr, 0);
    chk("rst_abort", o_abort, 0);
    chk("rst_ack0", o_ack_0, 0);
    @(negedge i_clk); i_arst_n = 1'b1;
    @(negedge i_clk);

    // single frame of 3 bytes
    i_req_0 = 1'b1; i_len_0 = 4'd3; i_data_0 = 8'hA1; i_tx_rdy = 1'b1;
    #1 chk("b_idle_gnt0", o_gnt_0, 0);
    @(negedge i_clk); #1;
    chk("b_gnt0", o_gnt_0, 1);
    chk("b_busy", o_busy, 1);
    chk("b_wr0", o_tx_wr, 1);
    chk("b_data0", o_tx_data, 8'hA1);
    chk("b_ack0", o_ack_0, 1);
    chk("b_ack1", o_ack_1, 0);
    @(negedge i_clk); i_data_0 = 8'hB2; #1;
    chk("b_wr1", o_tx_wr, 1);
    chk("b_data1", o_tx_data, 8'hB2);
    @(negedge i_clk); i_data_0 = 8'hC3; #1;
    chk("b_wr2", o_tx_wr, 1);
    chk("b_data2", o_tx_data, 8'hC3);
    chk("b_ack2", o_ack_0, 1);
    @(negedge i_clk); #1;
    chk("b_done_gnt0", o_gnt_0, 0);
    chk("b_done_busy", o_busy, 1);
    chk("b_done_wr", o_tx_wr, 0);
    i_req_0 = 1'b0;
    @(negedge i_clk); #1;
    chk("b_idle_busy", o_busy, 0);

    // contention from reset, both lengths 2
    @(negedge i_clk);
    i_arst_n = 1'b0;
    i_req_0 = 1'b1; i_req_1 = 1'b1; i_len_0 = 4'd2; i_len_1 = 4'd2;
    i_data_0 = 8'h10; i_data_1 = 8'h20;
    #1 chk("c_rst_busy", o_busy, 0);
    @(negedge i_clk); i_arst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge i_clk); #1;
      if (o_gnt_0 | o_gnt_1) break;
    end
    for (int k = 0; k < 11; k++) begin
      if (k > 0) begin
        @(negedge i_clk); #1;
      end
      chk($sformatf("c_seq%0d", k), {o_gnt_0, o_gnt_1, o_tx_wr}, ctab[k]);
      exp_data = ctab[k][2] ? 8'h10 : (ctab[k][1] ? 8'h20 : 8'h00);
      chk($sformatf("c_data%0d", k), o_tx_data, exp_data);
      if (k == 10) begin
        i_req_0 = 1'b0; i_req_1 = 1'b0;
      end
    end

    // backpressure on a 4-byte frame from requester 1
    @(negedge i_clk);
    i_req_1 = 1'b1; i_len_1 = 4'd4;
    nw = 0;
    for (int k = 0; k < 7; k++) begin
      @(negedge i_clk);
      i_tx_rdy = pat[k];
      i_data_1 = 8'h30 + 8'(k);
      #1;
      chk($sformatf("d_wr%0d", k), o_tx_wr, pat[k]);
      chk($sformatf("d_ack%0d", k), o_ack_1, pat[k]);
      if (o_tx_wr) begin
        chk($sformatf("d_data%0d", k), o_tx_data, 8'h30 + 8'(k));
        nw++;
      end
    end
    @(negedge i_clk); #1;
    chk("d_writes", nw, 4);
    chk("d_done_busy", o_busy, 1);
    chk("d_done_gnt1", o_gnt_1, 0);
    i_req_1 = 1'b0; i_tx_rdy = 1'b1;

    // abort after first of 4 bytes
    @(negedge i_clk);
    i_req_0 = 1'b1; i_len_0 = 4'd4; i_data_0 = 8'h77;
    @(negedge i_clk); #1;
    chk("e_wr1", o_tx_wr, 1);
    @(negedge i_clk); i_req_0 = 1'b0; #1;
    chk("e_wr_drop", o_tx_wr, 0);
    chk("e_ack_drop", o_ack_0, 0);
    chk("e_abort_early", o_abort, 0);
    @(negedge i_clk); #1;
    chk("e_abort", o_abort, 1);
    chk("e_gnt0", o_gnt_0, 0);
    chk("e_busy", o_busy, 1);
    chk("e_wr", o_tx_wr, 0);
    @(negedge i_clk); #1;
    chk("e_abort_clr", o_abort, 0);
    chk("e_idle_busy", o_busy, 0);

    // zero length on requester 1 writes exactly one byte
    i_req_1 = 1'b1; i_len_1 = 4'd0; i_data_1 = 8'h55;
    @(negedge i_clk); #1;
    chk("f_gnt1", o_gnt_1, 1);
    chk("f_wr", o_tx_wr, 1);
    chk("f_data", o_tx_data, 8'h55);
    @(negedge i_clk); #1;
    chk("f_wr_after", o_tx_wr, 0);
    chk("f_gnt_after", o_gnt_1, 0);
    i_req_1 = 1'b0;

    // reset during byte 2 of 5, then contention goes to requester 0
    @(negedge i_clk);
    i_req_0 = 1'b1; i_len_0 = 4'd5; i_data_0 = 8'h99;
    @(negedge i_clk); #1;
    chk("g_b1_wr", o_tx_wr, 1);
    @(negedge i_clk); #1;
    chk("g_b2_wr", o_tx_wr, 1);
    i_arst_n = 1'b0; i_req_1 = 1'b1;
    #1;
    chk("g_rst_wr", o_tx_wr, 0);
    chk("g_rst_gnt0", o_gnt_0, 0);
    chk("g_rst_busy", o_busy, 0);
    @(negedge i_clk); i_arst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge i_clk); #1;
      if (o_gnt_0 | o_gnt_1) break;
    end
    chk("g_win_gnt0", o_gnt_0, 1);
    chk("g_win_gnt1", o_gnt_1, 0);
    i_req_0 = 1'b0; i_req_1 = 1'b0;
    @(negedge i_clk);
    @(negedge i_clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pc_tx_frame_arbiter.md
PC_TX_FRAME_ARBITER -- requirements
Module: pc_tx_frame_arbiter

Interface
REQ-001 SHALL have parameter LEN_WIDTH, default 4, giving the width of frame-length inputs (max frame 2^LEN_WIDTH-1 bytes).
REQ-002 SHALL have parameter DATA_WIDTH, default 8, giving the UART byte width.
REQ-003 i_clk  input  1  single clock; all state on rising edge.
REQ-004 i_arst_n  input  1  asynchronous active-low reset.
REQ-005 i_req_0, i_req_1  input  1 each  requester frame request, held high until frame done.
REQ-006 i_len_0, i_len_1  input  LEN_WIDTH each  frame length in bytes, valid while request high.
REQ-007 i_data_0, i_data_1  input  DATA_WIDTH each  current byte of the requester's frame.
REQ-008 o_gnt_0, o_gnt_1  output  1 each  requester owns the UART TX path (one-hot or zero).
REQ-009 o_ack_0, o_ack_1  output  1 each  single-cycle pulse: current byte consumed, present next byte.
REQ-010 i_tx_rdy  input  1  UART transmitter can accept a byte this cycle.
REQ-011 o_tx_wr  output  1  UART write strobe.
REQ-012 o_tx_data  output  DATA_WIDTH  UART write byte.
REQ-013 o_abort  output  1  single-cycle pulse: granted frame aborted.
REQ-014 o_busy  output  1  high in any state other than IDLE.

Function
REQ-015 SHALL implement states IDLE, SEND, DONE.
REQ-016 IDLE: if any i_req_N high, next cycle SHALL enter SEND with o_gnt_N high and latch len = i_len_N (value 0 treated as 1) into a LEN_WIDTH byte counter target.
REQ-017 Arbitration SHALL be round-robin: with both requests high in IDLE, grant the requester not granted last; after reset, requester 0 has priority.
REQ-018 A single request SHALL be granted regardless of last-grant pointer; the pointer updates on every grant.
REQ-019 SEND: o_tx_wr SHALL equal i_tx_rdy AND granted i_req_N, combinationally; o_tx_data SHALL equal granted i_data_N, else 0.
REQ-020 o_ack_N SHALL equal o_tx_wr AND o_gnt_N (same cycle as the write).
REQ-021 Byte counter SHALL start at 0 on grant, increment on each o_tx_wr; write with counter = len-1 SHALL move to DONE.
REQ-022 i_tx_rdy low in SEND SHALL stall without write or ack; no timeout.
REQ-023 Granted i_req_N falling in SEND SHALL abort: no write that cycle, o_abort pulse next cycle, enter DONE.
REQ-024 DONE SHALL last exactly one cycle with both grants low, then IDLE; minimum gap between frames is 2 cycles (DONE, IDLE).
REQ-025 Changes of the non-granted requester's inputs SHALL have no effect during SEND/DONE.
REQ-026 o_gnt_N, o_abort, o_busy SHALL be registered; o_tx_wr, o_tx_data, o_ack_N combinational from state and inputs.
REQ-027 At most one of o_gnt_0/o_gnt_1 SHALL be high in any cycle.

Reset
REQ-028 Assertion of i_arst_n low SHALL immediately force IDLE, counter 0, pointer to "requester 1 last", and all outputs 0, including mid-frame.
REQ-029 Release SHALL be synchronous to i_clk (external synchronizer); first grant possible on the second edge after release.

Verification
REQ-030 Single frame: i_req_0=1, i_len_0=3, i_tx_rdy=1 -> o_gnt_0 one cycle later, 3 consecutive o_tx_wr with bytes A,B,C, 3 o_ack_0 pulses, DONE, o_busy low after 5 cycles total.
REQ-031 Contention: both requests high from reset, lengths 2 -> frame 0 sent first, then frame 1, then frame 0 again; grants never overlap.
REQ-032 Backpressure: i_len_1=4, i_tx_rdy toggling 1,0,0,1,1,0,1 -> exactly 4 writes, only in cycles where i_tx_rdy=1.
REQ-033 Abort: i_req_0 dropped after 1 of 4 bytes -> no further writes, o_abort one-cycle pulse, next frame granted normally.
REQ-034 Zero length: i_len_1=0 -> exactly one byte written.
REQ-035 Reset mid-frame: i_arst_n low during byte 2 of 5 -> o_tx_wr, grants, o_busy 0 same cycle; after release requester 0 wins contention.
